tl_rom_arbiter: RTL and testbench



---
 rtl/tl_rom_arbiter_if.sv | 40 ++++
 rtl/tl_rom_arbiter.sv | 168 ++++++++++++++++
 tb/tb_tl_rom_arbiter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/tl_rom_arbiter_if.sv
// TileLink-UL bundle (A and D channels) for the boot-ROM path.
// A master drives the A channel and d_ready. A slave drives a_ready and the D channel.
interface tilelink #(
  parameter int ADDR_W = 64
);
  logic              a_valid;
  logic              a_ready;
  logic [2:0]        a_opcode;
  logic [2:0]        a_param;
  logic [2:0]        a_size;
  logic [3:0]        a_source;
  logic [ADDR_W-1:0] a_address;
  logic [7:0]        a_mask;
  logic [63:0]       a_data;
  logic              a_corrupt;

  logic              d_valid;
  logic              d_ready;
  logic [2:0]        d_opcode;
  logic [1:0]        d_param;
  logic [2:0]        d_size;
  logic [3:0]        d_source;
  logic              d_denied;
  logic [63:0]       d_data;
  logic              d_corrupt;

  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
    input  a_ready,
    input  d_valid, d_opcode, d_param, d_size, d_source, d_denied, d_data, d_corrupt,
    output d_ready
  );

  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
    output a_ready,
    output d_valid, d_opcode, d_param, d_size, d_source, d_denied, d_data, d_corrupt,
    input  d_ready
  );
endinterface

// File: rtl/tl_rom_arbiter.sv
// Two-master round-robin TileLink-UL arbiter in front of the shared boot ROM.
// A grant is held until the single D beat returns. A watchdog synthesises an error beat if the ROM never answers.
module tl_rom_arbiter #(
  parameter logic [15:0] TIMEOUT = 16'd1024,
  parameter int          ADDR_W  = 64
) (
  input  logic     i_clk,
  input  logic     i_rst,
  tilelink.slave   m0,
  tilelink.slave   m1,
  tilelink.master  rom,
  output logic     o_timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_GRANT = 2'b01,
    S_RESP  = 2'b10
  } state_t;

  localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;

  state_t            r_state;
  state_t            w_next;
  logic              r_grant;
  logic              r_rr;
  logic [15:0]       r_wdog;
  logic              r_fired;
  logic [2:0]        r_opcode;
  logic [2:0]        r_param;
  logic [2:0]        r_size;
  logic [3:0]        r_source;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_mask;
  logic [63:0]       r_data;
  logic              r_corrupt;

  logic              w_any;
  logic              w_sel;
  logic              w_fire;
  logic              w_gnt_d_ready;
  logic              w_d_valid;
  logic [2:0]        w_d_opcode;
  logic [1:0]        w_d_param;
  logic [2:0]        w_d_size;
  logic [3:0]        w_d_source;
  logic              w_d_denied;
  logic [63:0]       w_d_data;
  logic              w_d_corrupt;

  // A lone requester always wins; rr_ptr only breaks ties.
  assign w_any         = m0.a_valid | m1.a_valid;
  assign w_sel         = (m0.a_valid && m1.a_valid) ? r_rr : m1.a_valid;
  assign w_fire        = (TIMEOUT != 16'd0) && (r_wdog == TIMEOUT - 16'd1) && (r_state == S_RESP);
  assign w_gnt_d_ready = r_grant ? m1.d_ready : m0.d_ready;

  assign rom.a_opcode  = r_opcode;
  assign rom.a_param   = r_param;
  assign rom.a_size    = r_size;
  assign rom.a_source  = r_source;
  assign rom.a_address = r_addr;
  assign rom.a_mask    = r_mask;
  assign rom.a_data    = r_data;
  assign rom.a_corrupt = r_corrupt;

  // A synthesised error beat replaces whatever the ROM presents while the watchdog is firing.
  assign w_d_valid   = (r_state == S_RESP) && (w_fire || rom.d_valid);
  assign w_d_opcode  = w_fire ? TL_ACCESS_ACK_DATA : rom.d_opcode;
  assign w_d_param   = w_fire ? 2'd0 : rom.d_param;
  assign w_d_size    = w_fire ? r_size : rom.d_size;
  assign w_d_source  = w_fire ? r_source : rom.d_source;
  assign w_d_denied  = w_fire ? 1'b1 : rom.d_denied;
  assign w_d_data    = w_fire ? 64'd0 : rom.d_data;
  assign w_d_corrupt = w_fire ? 1'b1 : rom.d_corrupt;

  assign m0.d_valid   = w_d_valid && !r_grant;
  assign m0.d_opcode  = w_d_opcode;
  assign m0.d_param   = w_d_param;
  assign m0.d_size    = w_d_size;
  assign m0.d_source  = w_d_source;
  assign m0.d_denied  = w_d_denied;
  assign m0.d_data    = w_d_data;
  assign m0.d_corrupt = w_d_corrupt;

  assign m1.d_valid   = w_d_valid && r_grant;
  assign m1.d_opcode  = w_d_opcode;
  assign m1.d_param   = w_d_param;
  assign m1.d_size    = w_d_size;
  assign m1.d_source  = w_d_source;
  assign m1.d_denied  = w_d_denied;
  assign m1.d_data    = w_d_data;
  assign m1.d_corrupt = w_d_corrupt;

  always_comb begin
    w_next        = r_state;
    rom.a_valid   = 1'b0;
    rom.d_ready   = 1'b0;
    m0.a_ready    = 1'b0;
    m1.a_ready    = 1'b0;
    o_timeout_err = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) w_next = S_GRANT;
      end
      S_GRANT: begin
        rom.a_valid = 1'b1;
        if (r_grant) m1.a_ready = rom.a_ready;
        else         m0.a_ready = rom.a_ready;
        if (rom.a_ready) w_next = S_RESP;
      end
      S_RESP: begin
        rom.d_ready   = w_fire ? 1'b1 : w_gnt_d_ready;
        o_timeout_err = w_fire && !r_fired;
        if (w_d_valid && w_gnt_d_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_grant   <= 1'b0;
      r_rr      <= 1'b0;
      r_wdog    <= 16'd0;
      r_fired   <= 1'b0;
      r_opcode  <= '0;
      r_param   <= '0;
      r_size    <= '0;
      r_source  <= '0;
      r_addr    <= '0;
      r_mask    <= '0;
      r_data    <= '0;
      r_corrupt <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant   <= w_sel;
            r_rr      <= ~w_sel;
            r_opcode  <= w_sel ? m1.a_opcode  : m0.a_opcode;
            r_param   <= w_sel ? m1.a_param   : m0.a_param;
            r_size    <= w_sel ? m1.a_size    : m0.a_size;
            r_source  <= w_sel ? m1.a_source  : m0.a_source;
            r_addr    <= w_sel ? m1.a_address : m0.a_address;
            r_mask    <= w_sel ? m1.a_mask    : m0.a_mask;
            r_data    <= w_sel ? m1.a_data    : m0.a_data;
            r_corrupt <= w_sel ? m1.a_corrupt : m0.a_corrupt;
          end
        end
        S_GRANT: begin
          if (rom.a_ready) begin
            r_wdog  <= 16'd0;
            r_fired <= 1'b0;
          end
        end
        S_RESP: begin
          // Freezing at the fire point holds the error beat until the requester takes it.
          if (w_fire) r_fired <= 1'b1;
          else if (!rom.d_valid && r_wdog != 16'hFFFF) r_wdog <= r_wdog + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tl_rom_arbiter.sv
// Directed bench for tl_rom_arbiter: round-robin grants, back-pressure, watchdog and mid-transaction reset.
module tb_tl_rom_arbiter;

  logic clk;
  logic rst;
  logic timeout_err;
  int   tests;
  int   fails;

  tilelink #(.ADDR_W(64)) m0_if ();
  tilelink #(.ADDR_W(64)) m1_if ();
  tilelink #(.ADDR_W(64)) rom_if ();

  tl_rom_arbiter #(.TIMEOUT(16'd8), .ADDR_W(64)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .m0            (m0_if),
    .m1            (m1_if),
    .rom           (rom_if),
    .o_timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    m0_if.a_valid = 0; m0_if.a_opcode = 3'd4; m0_if.a_param = 0; m0_if.a_size = 3'd3;
    m0_if.a_source = 4'd1; m0_if.a_address = 0; m0_if.a_mask = 8'hFF; m0_if.a_data = 0;
    m0_if.a_corrupt = 0; m0_if.d_ready = 1;
    m1_if.a_valid = 0; m1_if.a_opcode = 3'd4; m1_if.a_param = 0; m1_if.a_size = 3'd3;
    m1_if.a_source = 4'd2; m1_if.a_address = 0; m1_if.a_mask = 8'hFF; m1_if.a_data = 0;
    m1_if.a_corrupt = 0; m1_if.d_ready = 1;
    rom_if.a_ready = 0; rom_if.d_valid = 0; rom_if.d_opcode = 3'd1; rom_if.d_param = 0;
    rom_if.d_size = 3'd3; rom_if.d_source = 0; rom_if.d_denied = 0; rom_if.d_data = 0;
    rom_if.d_corrupt = 0;
  endtask

  task automatic do_reset();
    cyc(); rst = 1;
    cyc(); rst = 0;
    mid();
  endtask

  task automatic test_reset();
    cyc(); rst = 1; m0_if.a_valid = 1; m0_if.a_address = 64'h99;
    cyc();
    mid();
    tests++; if (rom_if.a_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_rom_a_valid: got %b expected 0", rom_if.a_valid); end
    tests++; if (m0_if.a_ready !== 1'b0) begin fails++; $display("[TB] FAIL reset_m0_a_ready: got %b expected 0", m0_if.a_ready); end
    tests++; if (m0_if.d_valid !== 1'b0 || m1_if.d_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_d_valid: got %b%b expected 00", m0_if.d_valid, m1_if.d_valid); end
    tests++; if (rom_if.d_ready !== 1'b0) begin fails++; $display("[TB] FAIL reset_rom_d_ready: got %b expected 0", rom_if.d_ready); end
    tests++; if (timeout_err !== 1'b0) begin fails++; $display("[TB] FAIL reset_timeout_err: got %b expected 0", timeout_err); end
    tests++; if (rom_if.a_address !== 64'h0) begin fails++; $display("[TB] FAIL reset_a_address: got %h expected 0", rom_if.a_address); end
    cyc(); rst = 0; m0_if.a_valid = 0; m0_if.a_address = 0;
    mid();
  endtask

  task automatic test_single_get();
    cyc(); m0_if.a_valid = 1; m0_if.a_address = 64'h10; m0_if.a_source = 4'd1; rom_if.a_ready = 1;
    mid();
    tests++; if (rom_if.a_valid !== 1'b0 || m0_if.a_ready !== 1'b0) begin fails++; $display("[TB] FAIL single_idle_no_grant: got a_valid=%b a_ready=%b expected 0 0", rom_if.a_valid, m0_if.a_ready); end
    cyc();
    mid();
    tests++; if (rom_if.a_valid !== 1'b1 || rom_if.a_address !== 64'h10) begin fails++; $display("[TB] FAIL single_a_forward: got a_valid=%b addr=%h expected 1 10", rom_if.a_valid, rom_if.a_address); end
    tests++; if (rom_if.a_source !== 4'd1 || rom_if.a_opcode !== 3'd4) begin fails++; $display("[TB] FAIL single_a_fields: got src=%h op=%h expected 1 4", rom_if.a_source, rom_if.a_opcode); end
    tests++; if (m0_if.a_ready !== 1'b1 || m1_if.a_ready !== 1'b0) begin fails++; $display("[TB] FAIL single_a_ready: got m0=%b m1=%b expected 1 0", m0_if.a_ready, m1_if.a_ready); end
    cyc(); m0_if.a_valid = 0; rom_if.a_ready = 0;
    mid();
    tests++; if (m0_if.d_valid !== 1'b0) begin fails++; $display("[TB] FAIL single_no_early_d: got %b expected 0", m0_if.d_valid); end
    cyc(); rom_if.d_valid = 1; rom_if.d_data = 64'hDEADBEEF_00000013; rom_if.d_source = 4'd1;
    mid();
    tests++; if (m0_if.d_valid !== 1'b1 || m0_if.d_data !== 64'hDEADBEEF_00000013) begin fails++; $display("[TB] FAIL single_d_beat: got valid=%b data=%h expected 1 deadbeef00000013", m0_if.d_valid, m0_if.d_data); end
    tests++; if (m0_if.d_source !== 4'b0001 || m1_if.d_valid !== 1'b0) begin fails++; $display("[TB] FAIL single_d_route: got src=%h m1_valid=%b expected 1 0", m0_if.d_source, m1_if.d_valid); end
    tests++; if (rom_if.d_ready !== 1'b1) begin fails++; $display("[TB] FAIL single_rom_d_ready: got %b expected 1", rom_if.d_ready); end
    cyc(); rom_if.d_valid = 0;
    mid();
    tests++; if (m0_if.d_valid !== 1'b0) begin fails++; $display("[TB] FAIL single_d_one_cycle: got %b expected 0", m0_if.d_valid); end
  endtask

  task automatic test_round_robin();
    do_reset();
    cyc(); m0_if.a_valid = 1; m0_if.a_address = 64'h0; m1_if.a_valid = 1; m1_if.a_address = 64'h8; rom_if.a_ready = 1;
    mid();
    cyc();
    mid();
    tests++; if (rom_if.a_address !== 64'h0 || m0_if.a_ready !== 1'b1 || m1_if.a_ready !== 1'b0) begin fails++; $display("[TB] FAIL rr_first_m0: got addr=%h m0=%b m1=%b expected 0 1 0", rom_if.a_address, m0_if.a_ready, m1_if.a_ready); end
    cyc(); m0_if.a_address = 64'h20; rom_if.d_valid = 1; rom_if.d_source = 4'd1; rom_if.d_data = 64'hA0;
    mid();
    tests++; if (m0_if.d_valid !== 1'b1 || m1_if.d_valid !== 1'b0) begin fails++; $display("[TB] FAIL rr_resp_m0: got m0=%b m1=%b expected 1 0", m0_if.d_valid, m1_if.d_valid); end
    tests++; if (m0_if.a_ready !== 1'b0 || m1_if.a_ready !== 1'b0) begin fails++; $display("[TB] FAIL rr_no_accept_in_resp: got m0=%b m1=%b expected 0 0", m0_if.a_ready, m1_if.a_ready); end
    cyc(); rom_if.d_valid = 0;
    mid();
    tests++; if (rom_if.a_valid !== 1'b0) begin fails++; $display("[TB] FAIL rr_idle_gap: got %b expected 0", rom_if.a_valid); end
    cyc();
    mid();
    tests++; if (rom_if.a_address !== 64'h8 || m1_if.a_ready !== 1'b1 || m0_if.a_ready !== 1'b0) begin fails++; $display("[TB] FAIL rr_second_m1: got addr=%h m1=%b m0=%b expected 8 1 0", rom_if.a_address, m1_if.a_ready, m0_if.a_ready); end
    cyc(); m1_if.a_valid = 0; rom_if.d_valid = 1; rom_if.d_source = 4'd2; rom_if.d_data = 64'hB1;
    mid();
    tests++; if (m1_if.d_valid !== 1'b1 || m1_if.d_data !== 64'hB1 || m0_if.d_valid !== 1'b0) begin fails++; $display("[TB] FAIL rr_resp_m1: got m1=%b data=%h m0=%b expected 1 b1 0", m1_if.d_valid, m1_if.d_data, m0_if.d_valid); end
    cyc(); rom_if.d_valid = 0;
    mid();
    cyc();
    mid();
    tests++; if (rom_if.a_address !== 64'h20 || m0_if.a_ready !== 1'b1) begin fails++; $display("[TB] FAIL rr_third_m0: got addr=%h m0=%b expected 20 1", rom_if.a_address, m0_if.a_ready); end
    cyc(); m0_if.a_valid = 0; rom_if.a_ready = 0; rom_if.d_valid = 1; rom_if.d_source = 4'd1;
    mid();
    tests++; if (m0_if.d_valid !== 1'b1) begin fails++; $display("[TB] FAIL rr_resp_m0_again: got %b expected 1", m0_if.d_valid); end
    cyc(); rom_if.d_valid = 0;
    mid();
  endtask

  task automatic test_a_stall();
    cyc(); m0_if.a_valid = 1; m0_if.a_address = 64'h30; rom_if.a_ready = 0;
    mid();
    for (int i = 0; i < 5; i++) begin
      cyc();
      mid();
      tests++; if (rom_if.a_valid !== 1'b1 || rom_if.a_address !== 64'h30 || m0_if.a_ready !== 1'b0) begin fails++; $display("[TB] FAIL stall_hold_%0d: got a_valid=%b addr=%h a_ready=%b expected 1 30 0", i, rom_if.a_valid, rom_if.a_address, m0_if.a_ready); end
    end
    cyc(); rom_if.a_ready = 1;
    mid();
    tests++; if (rom_if.a_valid !== 1'b1 || m0_if.a_ready !== 1'b1) begin fails++; $display("[TB] FAIL stall_accept: got a_valid=%b a_ready=%b expected 1 1", rom_if.a_valid, m0_if.a_ready); end
    cyc(); m0_if.a_valid = 0; rom_if.a_ready = 0; rom_if.d_valid = 1; rom_if.d_source = 4'd1;
    mid();
    tests++; if (m0_if.d_valid !== 1'b1) begin fails++; $display("[TB] FAIL stall_resp: got %b expected 1", m0_if.d_valid); end
    cyc(); rom_if.d_valid = 0;
    mid();
  endtask

  task automatic test_d_backpressure();
    cyc(); m0_if.a_valid = 1; m0_if.a_address = 64'h40; m0_if.d_ready = 0; rom_if.a_ready = 1;
    mid();
    cyc();
    mid();
    for (int i = 0; i < 3; i++) begin
      cyc(); m0_if.a_valid = 0; rom_if.a_ready = 0; rom_if.d_valid = 1; rom_if.d_data = 64'h1234;
      mid();
      tests++; if (rom_if.d_ready !== 1'b0 || m0_if.d_valid !== 1'b1 || m0_if.d_data !== 64'h1234) begin fails++; $display("[TB] FAIL bp_stall_%0d: got d_ready=%b valid=%b data=%h expected 0 1 1234", i, rom_if.d_ready, m0_if.d_valid, m0_if.d_data); end
    end
    cyc(); m0_if.d_ready = 1;
    mid();
    tests++; if (rom_if.d_ready !== 1'b1 || m0_if.d_valid !== 1'b1) begin fails++; $display("[TB] FAIL bp_handshake: got d_ready=%b valid=%b expected 1 1", rom_if.d_ready, m0_if.d_valid); end
    cyc();
    mid();
    tests++; if (m0_if.d_valid !== 1'b0 || rom_if.d_ready !== 1'b0) begin fails++; $display("[TB] FAIL bp_left_resp: got valid=%b d_ready=%b expected 0 0", m0_if.d_valid, rom_if.d_ready); end
    cyc(); rom_if.d_valid = 0; rom_if.d_data = 0;
    mid();
  endtask

  task automatic test_timeout();
    cyc(); m0_if.a_valid = 1; m0_if.a_address = 64'h50; m0_if.a_source = 4'd5; rom_if.a_ready = 1;
    mid();
    cyc();
    mid();
    tests++; if (m0_if.a_ready !== 1'b1) begin fails++; $display("[TB] FAIL wd_accept: got %b expected 1", m0_if.a_ready); end
    for (int i = 0; i < 7; i++) begin
      cyc(); m0_if.a_valid = 0; rom_if.a_ready = 0;
      mid();
      tests++; if (m0_if.d_valid !== 1'b0 || timeout_err !== 1'b0) begin fails++; $display("[TB] FAIL wd_early_%0d: got valid=%b err=%b expected 0 0", i, m0_if.d_valid, timeout_err); end
    end
    cyc();
    mid();
    tests++; if (m0_if.d_valid !== 1'b1 || m0_if.d_denied !== 1'b1 || m0_if.d_corrupt !== 1'b1) begin fails++; $display("[TB] FAIL wd_error_beat: got valid=%b denied=%b corrupt=%b expected 1 1 1", m0_if.d_valid, m0_if.d_denied, m0_if.d_corrupt); end
    tests++; if (m0_if.d_data !== 64'h0 || m0_if.d_source !== 4'd5 || m0_if.d_opcode !== 3'd1) begin fails++; $display("[TB] FAIL wd_error_fields: got data=%h src=%h op=%h expected 0 5 1", m0_if.d_data, m0_if.d_source, m0_if.d_opcode); end
    tests++; if (timeout_err !== 1'b1 || rom_if.d_ready !== 1'b1) begin fails++; $display("[TB] FAIL wd_pulse: got err=%b d_ready=%b expected 1 1", timeout_err, rom_if.d_ready); end
    cyc(); m0_if.a_valid = 1; m0_if.a_address = 64'h60; m0_if.a_source = 4'd1; rom_if.a_ready = 1;
    mid();
    tests++; if (timeout_err !== 1'b0 || m0_if.d_valid !== 1'b0) begin fails++; $display("[TB] FAIL wd_single_pulse: got err=%b valid=%b expected 0 0", timeout_err, m0_if.d_valid); end
    cyc();
    mid();
    tests++; if (rom_if.a_valid !== 1'b1 || rom_if.a_address !== 64'h60 || m0_if.a_ready !== 1'b1) begin fails++; $display("[TB] FAIL wd_next_grant: got a_valid=%b addr=%h a_ready=%b expected 1 60 1", rom_if.a_valid, rom_if.a_address, m0_if.a_ready); end
    cyc(); m0_if.a_valid = 0; rom_if.a_ready = 0; rom_if.d_valid = 1; rom_if.d_source = 4'd1;
    mid();
    tests++; if (m0_if.d_valid !== 1'b1 || m0_if.d_denied !== 1'b0) begin fails++; $display("[TB] FAIL wd_next_resp: got valid=%b denied=%b expected 1 0", m0_if.d_valid, m0_if.d_denied); end
    cyc(); rom_if.d_valid = 0;
    mid();
  endtask

  task automatic test_reset_mid();
    cyc(); m0_if.a_valid = 1; m0_if.a_address = 64'h70; rom_if.a_ready = 1;
    mid();
    cyc();
    mid();
    cyc(); m0_if.a_valid = 0; rst = 1;
    mid();
    cyc(); rst = 0; rom_if.d_valid = 1; rom_if.d_source = 4'd1;
    m0_if.a_valid = 1; m0_if.a_address = 64'h80; m1_if.a_valid = 1; m1_if.a_address = 64'h88;
    mid();
    tests++; if (m0_if.d_valid !== 1'b0 || m1_if.d_valid !== 1'b0 || rom_if.a_valid !== 1'b0) begin fails++; $display("[TB] FAIL rstmid_valids: got m0d=%b m1d=%b a_valid=%b expected 0 0 0", m0_if.d_valid, m1_if.d_valid, rom_if.a_valid); end
    tests++; if (rom_if.d_ready !== 1'b0 || m0_if.a_ready !== 1'b0) begin fails++; $display("[TB] FAIL rstmid_readies: got d_ready=%b a_ready=%b expected 0 0", rom_if.d_ready, m0_if.a_ready); end
    cyc(); rom_if.d_valid = 0;
    mid();
    tests++; if (rom_if.a_address !== 64'h80 || m0_if.a_ready !== 1'b1 || m1_if.a_ready !== 1'b0) begin fails++; $display("[TB] FAIL rstmid_regrant_m0: got addr=%h m0=%b m1=%b expected 80 1 0", rom_if.a_address, m0_if.a_ready, m1_if.a_ready); end
    cyc(); m0_if.a_valid = 0; m1_if.a_valid = 0; rom_if.a_ready = 0; rom_if.d_valid = 1;
    mid();
    tests++; if (m0_if.d_valid !== 1'b1) begin fails++; $display("[TB] FAIL rstmid_resp: got %b expected 1", m0_if.d_valid); end
    cyc(); rom_if.d_valid = 0;
    mid();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1;
    clear_inputs();
    test_reset();
    test_single_get();
    test_round_robin();
    test_a_stall();
    test_d_backpressure();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
